// File: rtl/fft_bfly_scheduler.sv
// Issues every butterfly of an in-place radix-2 FFT, stage by stage, over a valid/ready channel.
// In-flight butterflies are bounded, and each stage fully drains before the next stage starts.
module fft_bfly_scheduler #(
  parameter int LOG2N   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cfg_inverse_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_ack_o,
  output logic             bf_valid_o,
  input  logic             bf_ready_i,
  output logic [LOG2N-1:0] bf_addr_a_o,
  output logic [LOG2N-1:0] bf_addr_b_o,
  output logic [LOG2N-2:0] bf_tw_idx_o,
  output logic             bf_tw_conj_o,
  output logic [3:0]       bf_stage_o,
  output logic             bf_last_o,
  input  logic             bf_ack_i
);

  localparam int KW = LOG2N - 1;
  localparam logic [3:0]       LAST_STAGE = 4'(LOG2N - 1);
  localparam logic [KW-1:0]    LAST_K     = '1;
  localparam logic [3:0]       MAX_OUT_C  = 4'(MAX_OUT);
  localparam logic [LOG2N-1:0] ONE        = 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    out_q, out_d;
  logic          inv_q, inv_d;
  logic          err_q, err_d;

  logic             active, xfer, ack_ok;
  logic [LOG2N-1:0] k_ext, span, pos, addr_a;

  assign active = (state_q == S_ISSUE);
  assign xfer   = bf_valid_o & bf_ready_i;
  assign ack_ok = bf_ack_i & (out_q != 4'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      out_q   <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      out_q   <= out_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
    end
  end

  // A spurious ack (count already zero) is flagged and never decrements the count.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    inv_d   = inv_q;
    err_d   = err_q | (bf_ack_i & (out_q == 4'd0));
    out_d   = out_q + {3'b000, xfer} - {3'b000, ack_ok};
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_ISSUE;
          stage_d = '0;
          k_d     = '0;
          inv_d   = cfg_inverse_i;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST_K) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_q == 4'd0) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            stage_d = stage_q + 4'd1;
            k_d     = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      stage_d = '0;
      k_d     = '0;
      out_d   = '0;
    end
  end

  // Butterfly k of stage s pairs addresses that differ only in bit s.
  always_comb begin
    k_ext  = {1'b0, k_q};
    span   = ONE << stage_q;
    pos    = k_ext & (span - ONE);
    addr_a = ((k_ext >> stage_q) << (stage_q + 4'd1)) | pos;
  end

  assign bf_valid_o   = active && (out_q < MAX_OUT_C);
  assign bf_addr_a_o  = active ? addr_a : '0;
  assign bf_addr_b_o  = active ? (addr_a + span) : '0;
  assign bf_tw_idx_o  = active ? (pos[LOG2N-2:0] << (LAST_STAGE - stage_q)) : '0;
  assign bf_tw_conj_o = inv_q;
  assign bf_stage_o   = stage_q;
  assign bf_last_o    = active && (stage_q == LAST_STAGE) && (k_q == LAST_K);
  assign busy_o       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign err_ack_o    = err_q;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Directed checks of fft_bfly_scheduler with LOG2N=4, MAX_OUT=4: timing, addressing,
// backpressure, abort, inverse latching and spurious-ack flagging.
module tb_fft_bfly_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfgInverse = 1'b0;
  logic       busy, done, errAck, bfValid, bfTwConj, bfLast;
  logic       bfReady = 1'b1;
  logic [3:0] bfAddrA, bfAddrB, bfStage;
  logic [2:0] bfTwIdx;
  logic       bfAck;
  logic       manualAck = 1'b0;
  logic       autoAck = 1'b0;
  logic       autoAckQ = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycAbs = 0;
  int xferCount = 0;
  int doneCount = 0;
  int doneCyc = 0;
  int   xCyc[256];
  int   xA[256];
  int   xB[256];
  int   xTw[256];
  logic xLast[256];
  logic xConj[256];

  fft_bfly_scheduler #(.LOG2N(4), .MAX_OUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .cfg_inverse_i(cfgInverse), .busy_o(busy), .done_o(done), .err_ack_o(errAck),
    .bf_valid_o(bfValid), .bf_ready_i(bfReady), .bf_addr_a_o(bfAddrA),
    .bf_addr_b_o(bfAddrB), .bf_tw_idx_o(bfTwIdx), .bf_tw_conj_o(bfTwConj),
    .bf_stage_o(bfStage), .bf_last_o(bfLast), .bf_ack_i(bfAck)
  );

  always #5 clk = ~clk;

  assign bfAck = autoAckQ | manualAck;

  // Datapath stand-in: retires each butterfly one cycle after it was accepted.
  always @(posedge clk) autoAckQ <= autoAck && bfValid && bfReady;

  // Logs every transfer and done pulse with the index of the cycle it happened in.
  always @(posedge clk) begin
    cycAbs <= cycAbs + 1;
    if (bfValid === 1'b1 && bfReady === 1'b1) begin
      if (xferCount < 256) begin
        xCyc[xferCount]  <= cycAbs;
        xA[xferCount]    <= 32'(bfAddrA);
        xB[xferCount]    <= 32'(bfAddrB);
        xTw[xferCount]   <= 32'(bfTwIdx);
        xLast[xferCount] <= bfLast;
        xConj[xferCount] <= bfTwConj;
      end
      xferCount <= xferCount + 1;
    end
    if (done === 1'b1) begin
      doneCount <= doneCount + 1;
      doneCyc   <= cycAbs;
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one complete transform with auto-acks; optionally toggles cfg_inverse and start meanwhile.
  task automatic runFull(input string tag, input logic inv, input bit noisy, output int baseOut);
    int base, dbase, startCyc, lastCnt, conjCnt, idx;
    bit finished;
    base = xferCount;
    dbase = doneCount;
    baseOut = base;
    autoAck = 1'b1;
    cfgInverse = inv;
    start = 1'b1;
    startCyc = cycAbs;
    applyStimulus();
    start = 1'b0;
    checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
    checkOutput({tag, " err_ack cleared by start"}, 32'(errAck), 32'd0);
    finished = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (doneCount > dbase) begin
        finished = 1'b1;
        break;
      end
      if (noisy) begin
        start = (done === 1'b1) ? 1'b0 : ((i % 2) == 0);
        cfgInverse = ~cfgInverse;
      end
      applyStimulus();
    end
    start = 1'b0;
    cfgInverse = 1'b0;
    checkOutput({tag, " completed in time"}, 32'(finished), 32'd1);
    checkOutput({tag, " transfer count"}, 32'(xferCount - base), 32'd32);
    checkOutput({tag, " done pulse count"}, 32'(doneCount - dbase), 32'd1);
    checkOutput({tag, " done cycle"}, 32'(doneCyc - startCyc), 32'd41);
    lastCnt = 0;
    conjCnt = 0;
    for (int i = 0; i < 32; i++) begin
      idx = base + i;
      if (idx < 256) begin
        checkOutput($sformatf("%s xfer%0d cycle", tag, i), 32'(xCyc[idx] - startCyc),
                    32'(1 + 10 * (i / 8) + (i % 8)));
        if (xLast[idx] === 1'b1) lastCnt++;
        if (xConj[idx] === inv) conjCnt++;
      end
    end
    checkOutput({tag, " bf_last on 32nd"}, 32'(xLast[(base + 31) % 256]), 32'd1);
    checkOutput({tag, " bf_last count"}, 32'(lastCnt), 32'd1);
    checkOutput({tag, " tw_conj matches latched"}, 32'(conjCnt), 32'd32);
    checkOutput({tag, " busy low after done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base, d0;
    bit found;

    // Reset values.
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst err_ack", 32'(errAck), 32'd0);
    checkOutput("rst valid", 32'(bfValid), 32'd0);
    checkOutput("rst addr_a", 32'(bfAddrA), 32'd0);
    checkOutput("rst addr_b", 32'(bfAddrB), 32'd0);
    checkOutput("rst stage", 32'(bfStage), 32'd0);
    checkOutput("rst last", 32'(bfLast), 32'd0);

    // T6: spurious ack in IDLE is flagged, count stays 0, next start clears the flag.
    manualAck = 1'b1;
    applyStimulus();
    manualAck = 1'b0;
    checkOutput("T6 err_ack set", 32'(errAck), 32'd1);
    checkOutput("T6 still idle", 32'(busy), 32'd0);
    base = xferCount;
    autoAck = 1'b0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("T6 err_ack cleared", 32'(errAck), 32'd0);
    repeat (8) applyStimulus();
    checkOutput("T6 window of 4", 32'(xferCount - base), 32'd4);
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("T6 abort idle", 32'(busy), 32'd0);

    // T1/T2: full run with immediate acks, then spot-check addressing.
    runFull("T1", 1'b0, 1'b0, base);
    checkOutput("T2 s0k0 a", 32'(xA[base + 0]), 32'd0);
    checkOutput("T2 s0k0 b", 32'(xB[base + 0]), 32'd1);
    checkOutput("T2 s0k0 tw", 32'(xTw[base + 0]), 32'd0);
    checkOutput("T2 s1k3 a", 32'(xA[base + 11]), 32'd5);
    checkOutput("T2 s1k3 b", 32'(xB[base + 11]), 32'd7);
    checkOutput("T2 s1k3 tw", 32'(xTw[base + 11]), 32'd4);
    checkOutput("T2 s2k3 a", 32'(xA[base + 19]), 32'd3);
    checkOutput("T2 s2k3 b", 32'(xB[base + 19]), 32'd7);
    checkOutput("T2 s2k3 tw", 32'(xTw[base + 19]), 32'd6);
    checkOutput("T2 s3k5 a", 32'(xA[base + 29]), 32'd5);
    checkOutput("T2 s3k5 b", 32'(xB[base + 29]), 32'd13);
    checkOutput("T2 s3k5 tw", 32'(xTw[base + 29]), 32'd5);

    // T3: stall with bf_ready=0, then window limit with acks withheld.
    autoAck = 1'b0;
    bfReady = 1'b0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("T3 stall%0d valid", i), 32'(bfValid), 32'd1);
      checkOutput($sformatf("T3 stall%0d a", i), 32'(bfAddrA), 32'd0);
      checkOutput($sformatf("T3 stall%0d b", i), 32'(bfAddrB), 32'd1);
      checkOutput($sformatf("T3 stall%0d tw", i), 32'(bfTwIdx), 32'd0);
      applyStimulus();
    end
    bfReady = 1'b1;
    base = xferCount;
    repeat (6) applyStimulus();
    checkOutput("T3 four issued", 32'(xferCount - base), 32'd4);
    checkOutput("T3 valid low at limit", 32'(bfValid), 32'd0);
    checkOutput("T3 busy at limit", 32'(busy), 32'd1);
    manualAck = 1'b1;
    applyStimulus();
    manualAck = 1'b0;
    checkOutput("T3 valid after ack", 32'(bfValid), 32'd1);
    applyStimulus();
    checkOutput("T3 one more issued", 32'(xferCount - base), 32'd5);
    checkOutput("T3 valid low again", 32'(bfValid), 32'd0);
    checkOutput("T3 fifth a", 32'(xA[(base + 4) % 256]), 32'd8);
    checkOutput("T3 fifth b", 32'(xB[(base + 4) % 256]), 32'd9);
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("T3 abort idle", 32'(busy), 32'd0);

    // T4: abort at stage 2, k=3; late ack flags error; then a clean run.
    d0 = doneCount;
    autoAck = 1'b1;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bfValid === 1'b1 && bfStage === 4'd2 && bfAddrA === 4'd3) begin
        found = 1'b1;
        break;
      end
      applyStimulus();
    end
    checkOutput("T4 reached s2k3", 32'(found), 32'd1);
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("T4 busy after abort", 32'(busy), 32'd0);
    checkOutput("T4 valid after abort", 32'(bfValid), 32'd0);
    checkOutput("T4 done after abort", 32'(done), 32'd0);
    applyStimulus();
    checkOutput("T4 late ack err", 32'(errAck), 32'd1);
    checkOutput("T4 no done pulse", 32'(doneCount - d0), 32'd0);
    runFull("T4rerun", 1'b0, 1'b0, base);

    // T5: inverse latched at start, cfg_inverse and start toggled while busy.
    runFull("T5", 1'b1, 1'b1, base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
